// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: shared definitions for the FIR stream controller.
//   ser_state_e    - serializer FSM states
//   BYTE_W_DEFAULT - default byte width
//   ser_width()    - width of the serializer shift register (OUT_BYTES*BYTE_W)
package fir_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_NEXT
    } ser_state_e;

    localparam int unsigned BYTE_W_DEFAULT = 8;

    function automatic int unsigned ser_width(input int unsigned out_bytes,
                                              input int unsigned byte_w);
        return out_bytes * byte_w;
    endfunction

endpackage

// File: rtl/fir_stream_fifo.sv
// fir_stream_fifo: synchronous FIFO, first-word fall-through read data.
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   push_i, wdata_i  - write request and data (ignored when full unless popping)
//   pop_i, rdata_o   - read request (ignored when empty) and head-of-queue data
//   full_o, empty_o  - occupancy flags
//   level_o          - occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fir_stream_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: byte stream <-> FIR core controller.
//   CLOCK_50, rst          - clock, asynchronous active-low reset
//   data_ready, inp        - received byte strobe (rising edge) and byte
//   FIR_input, input_valid - assembled sample (MS byte first) and 1-cycle pulse
//   FIR_output, output_valid - FIR result and its 1-cycle pulse (pushed to FIFO)
//   busy                   - transmitter busy
//   TxD_start, TxD         - transmit request pulse and byte (held until busy falls)
//   overflow               - sticky: a result was dropped on a full FIFO
//   fifo_level             - output FIFO occupancy
// Optional macro FIR_STREAM_STATS_EN adds rx_samples/tx_samples counters.
module fir_stream_ctrl
    import fir_stream_pkg::*;
#(
    parameter int unsigned BYTE_W       = BYTE_W_DEFAULT,
    parameter int unsigned SAMPLE_BYTES = 2,
    parameter int unsigned OUT_W        = 17,
    parameter int unsigned OUT_BYTES    = 3,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                           CLOCK_50,
    input  logic                           rst,
    input  logic                           data_ready,
    input  logic [BYTE_W-1:0]              inp,
    output logic [SAMPLE_BYTES*BYTE_W-1:0] FIR_input,
    output logic                           input_valid,
    input  logic [OUT_W-1:0]               FIR_output,
    input  logic                           output_valid,
    input  logic                           busy,
    output logic                           TxD_start,
    output logic [BYTE_W-1:0]              TxD,
    output logic                           overflow,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
`ifdef FIR_STREAM_STATS_EN
    ,
    output logic [15:0]                    rx_samples,
    output logic [15:0]                    tx_samples
`endif
);
    localparam int unsigned SAMPLE_W = SAMPLE_BYTES * BYTE_W;
    localparam int unsigned SER_W    = ser_width(OUT_BYTES, BYTE_W);
    localparam int unsigned BCW      = $clog2(OUT_BYTES + 1);

    // ---------------- receive / sample assembly ----------------
    logic                dr_prev_q;
    logic [2:0]          rx_cnt_q, rx_cnt_d;
    logic [SAMPLE_W-1:0] asm_q, asm_d, fir_in_q, fir_in_d;
    logic                in_valid_q, in_valid_d;
    logic                rx_edge;

    assign rx_edge = data_ready & ~dr_prev_q;

    always_comb begin
        asm_d      = asm_q;
        rx_cnt_d   = rx_cnt_q;
        fir_in_d   = fir_in_q;
        in_valid_d = 1'b0;
        if (rx_edge) begin
            asm_d               = asm_q << BYTE_W;
            asm_d[BYTE_W-1:0]   = inp;
            if (rx_cnt_q == 3'(SAMPLE_BYTES - 1)) begin
                rx_cnt_d   = '0;
                fir_in_d   = asm_d;
                in_valid_d = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            dr_prev_q  <= 1'b0;
            rx_cnt_q   <= '0;
            asm_q      <= '0;
            fir_in_q   <= '0;
            in_valid_q <= 1'b0;
        end else begin
            dr_prev_q  <= data_ready;
            rx_cnt_q   <= rx_cnt_d;
            asm_q      <= asm_d;
            fir_in_q   <= fir_in_d;
            in_valid_q <= in_valid_d;
        end
    end

    assign FIR_input   = fir_in_q;
    assign input_valid = in_valid_q;

    // ---------------- output FIFO ----------------
    logic [SER_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic             overflow_q;

    fir_stream_fifo #(
        .WIDTH (SER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_ni  (rst),
        .push_i  (output_valid),
        .wdata_i (SER_W'(FIR_output)),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (output_valid && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

    // ---------------- serializer FSM ----------------
    ser_state_e       state_q, state_d;
    logic [SER_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic             tx_done;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bcnt_d    = bcnt_q;
        fifo_pop  = 1'b0;
        TxD_start = 1'b0;
        tx_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !busy) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    bcnt_d   = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                TxD_start = 1'b1;
                state_d   = ST_WAIT_HI;
            end
            ST_WAIT_HI: if (busy)  state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (!busy) state_d = ST_NEXT;
            ST_NEXT: begin
                if (bcnt_q == BCW'(OUT_BYTES - 1)) begin
                    tx_done = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    shreg_d = shreg_q << BYTE_W;
                    bcnt_d  = bcnt_q + BCW'(1);
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // TxD only changes on the NEXT->SEND shift, so it is stable while waiting on busy.
    assign TxD = shreg_q[SER_W-1 -: BYTE_W];

`ifdef FIR_STREAM_STATS_EN
    logic [15:0] rx_samples_q, tx_samples_q;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            rx_samples_q <= '0;
            tx_samples_q <= '0;
        end else begin
            if (in_valid_q) rx_samples_q <= rx_samples_q + 16'd1;
            if (tx_done)    tx_samples_q <= tx_samples_q + 16'd1;
        end
    end

    assign rx_samples = rx_samples_q;
    assign tx_samples = tx_samples_q;
`else
    logic unused_tx_done;
    assign unused_tx_done = tx_done;
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl with default parameters.
module tb_fir_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst, data_ready, output_valid, force_busy, busy;
    logic        mb = 1'b0;
    logic [7:0]  inp;
    logic [15:0] fir_input;
    logic        input_valid, txd_start, overflow;
    logic [16:0] fir_output;
    logic [7:0]  txd;
    logic [2:0]  fifo_level;
`ifdef FIR_STREAM_STATS_EN
    logic [15:0] rx_samples, tx_samples;
`endif

    always #5 clk = ~clk;
    assign busy = force_busy | mb;

    fir_stream_ctrl dut (
        .CLOCK_50     (clk),
        .rst          (rst),
        .data_ready   (data_ready),
        .inp          (inp),
        .FIR_input    (fir_input),
        .input_valid  (input_valid),
        .FIR_output   (fir_output),
        .output_valid (output_valid),
        .busy         (busy),
        .TxD_start    (txd_start),
        .TxD          (txd),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
`ifdef FIR_STREAM_STATS_EN
        ,
        .rx_samples   (rx_samples),
        .tx_samples   (tx_samples)
`endif
    );

    int unsigned tests = 0, fails = 0;
    int unsigned sc = 0, mcnt = 0, hcnt = 0;
    int unsigned exp_rx = 0, exp_tx = 0;
    logic [7:0]  sb[$];
    logic [7:0]  hv;
    bit          hold = 0, saw_busy = 0;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp;
    } rx_vec_t;

    typedef struct {
        logic [16:0] val;
        logic [7:0]  e2;
        logic [7:0]  e1;
        logic [7:0]  e0;
    } tx_vec_t;

    rx_vec_t rx_tab[4];
    tx_vec_t tx_tab[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmit scoreboard and busy model: busy rises 2 cycles after each start for 3 cycles.
    always @(negedge clk) begin
        if (!rst) begin
            mb = 1'b0; mcnt = 0; hcnt = 0; hold = 0; saw_busy = 0;
        end else begin
            if (txd_start) begin
                sc++;
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL tx_unexpected: got start with byte %0h, expected no start", txd);
                end else begin
                    chk("tx_byte", txd, sb.pop_front());
                end
                hold = 1; saw_busy = 0; hv = txd; mcnt = 2;
            end else if (hold) begin
                chk("tx_hold", txd, hv);
                if (busy) saw_busy = 1;
                else if (saw_busy) hold = 0;
            end
            if (hcnt != 0) begin
                hcnt--;
                if (hcnt == 0) mb = 1'b0;
            end else if (mcnt != 0) begin
                mcnt--;
                if (mcnt == 0) begin mb = 1'b1; hcnt = 3; end
            end
        end
    end

    task automatic rx_byte(input logic [7:0] b, input bit last, input logic [15:0] exp);
        @(negedge clk); inp = b; data_ready = 1'b1;
        @(negedge clk); data_ready = 1'b0;
        chk("rx_valid", input_valid, last);
        if (last) begin
            chk("rx_data", fir_input, exp);
            exp_rx++;
        end
        @(negedge clk);
        chk("rx_valid_pulse", input_valid, 0);
    endtask

    task automatic expect_sample(input logic [16:0] v);
        logic [23:0] w;
        w = {7'b0, v};
        sb.push_back(w[23:16]);
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
    endtask

    task automatic push_out(input logic [16:0] v);
        @(negedge clk); fir_output = v; output_valid = 1'b1;
        @(negedge clk); output_valid = 1'b0;
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && fifo_level == 0 && mb == 1'b0 && mcnt == 0) break;
        end
        chk("drain_sb_empty", sb.size(), 0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int unsigned s0;
        rx_tab[0] = '{8'h12, 8'h34, 16'h1234};
        rx_tab[1] = '{8'hFF, 8'h00, 16'hFF00};
        rx_tab[2] = '{8'h00, 8'hFF, 16'h00FF};
        rx_tab[3] = '{8'hA5, 8'h5A, 16'hA55A};
        tx_tab[0] = '{17'h1ABCD, 8'h01, 8'hAB, 8'hCD};
        tx_tab[1] = '{17'h00000, 8'h00, 8'h00, 8'h00};
        tx_tab[2] = '{17'h1FFFF, 8'h01, 8'hFF, 8'hFF};
        tx_tab[3] = '{17'h0F00F, 8'h00, 8'hF0, 8'h0F};

        rst = 1'b0; data_ready = 1'b0; inp = '0;
        output_valid = 1'b0; fir_output = '0; force_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fir_input", fir_input, 0);
        chk("rst_input_valid", input_valid, 0);
        chk("rst_txd_start", txd_start, 0);
        chk("rst_txd", txd, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_fifo_level", fifo_level, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            rx_byte(rx_tab[i].b0, 1'b0, 16'h0);
            rx_byte(rx_tab[i].b1, 1'b1, rx_tab[i].exp);
        end

        // Held-high strobe contributes one byte only.
        @(negedge clk); inp = 8'hAA; data_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("held_no_valid", input_valid, 0);
        end
        data_ready = 1'b0;
        @(negedge clk);
        rx_byte(8'h55, 1'b1, 16'hAA55);

        for (int i = 0; i < 4; i++) begin
            s0 = sc;
            sb.push_back(tx_tab[i].e2);
            sb.push_back(tx_tab[i].e1);
            sb.push_back(tx_tab[i].e0);
            push_out(tx_tab[i].val);
            drain();
            chk("tx_start_count", sc - s0, 3);
            exp_tx++;
        end

        // Fill, then push on the same cycle as the IDLE pop.
        @(negedge clk); force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_sample(17'h10000 + 17'(i) * 17'h01111);
            push_out(17'h10000 + 17'(i) * 17'h01111);
        end
        chk("full_level", fifo_level, 4);
        chk("full_no_ovf", overflow, 0);
        @(negedge clk); force_busy = 1'b0; fir_output = 17'h0BEEF; output_valid = 1'b1;
        expect_sample(17'h0BEEF);
        @(negedge clk); output_valid = 1'b0;
        chk("pushpop_level", fifo_level, 4);
        chk("pushpop_no_ovf", overflow, 0);
        s0 = sc;
        drain();
        chk("pushpop_starts", sc - s0, 15);
        exp_tx += 5;

        // Overflow: fifth push while full and blocked is dropped.
        @(negedge clk); force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_sample(17'h1FFFF - 17'(i));
            push_out(17'h1FFFF - 17'(i));
        end
        push_out(17'h12345);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_set", overflow, 1);
        s0 = sc;
        @(negedge clk); force_busy = 1'b0;
        drain();
        chk("ovf_starts", sc - s0, 12);
        chk("ovf_sticky", overflow, 1);
        exp_tx += 4;

`ifdef FIR_STREAM_STATS_EN
        chk("stats_rx", rx_samples, exp_rx);
        chk("stats_tx", tx_samples, exp_tx);
`endif

        // Asynchronous reset in WAIT_LO with a partial sample pending.
        rx_byte(8'hEE, 1'b0, 16'h0);
        expect_sample(17'h1ABCD);
        push_out(17'h1ABCD);
        expect_sample(17'h00F0F);
        push_out(17'h00F0F);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mb) break;
        end
        chk("wait_lo_reached", mb, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_txd_start", txd_start, 0);
        chk("arst_fifo_level", fifo_level, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_input_valid", input_valid, 0);
        chk("arst_txd", txd, 0);
        chk("arst_fir_input", fir_input, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        rx_byte(8'h12, 1'b0, 16'h0);
        rx_byte(8'h34, 1'b1, 16'h1234);
`ifdef FIR_STREAM_STATS_EN
        chk("stats_rx_after_rst", rx_samples, 1);
        chk("stats_tx_after_rst", tx_samples, 0);
`endif
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
